// File: rtl/activation_pkg.sv
// activation_pkg: FSM states, saturation and sizing helpers shared by activation_mac_q.
//   state_t    : ACCUM, SAT, DIVIDE, OUTPUT
//   one_of     : ONE = 2^FRAC
//   acc_width  : ACC_W = 2*WIDTH + GUARD
//   saturate   : clamp a sign-extended value to the signed range of w bits
package activation_pkg;
    typedef enum logic [1:0] {ACCUM, SAT, DIVIDE, OUTPUT} state_t;
    function automatic int one_of(input int frac);
        return 1 << frac;
    endfunction
    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/activation_mac_q_if.sv
// activation_mac_q_if: pair input stream and result output stream of activation_mac_q.
//   input_x/input_theta/input_stb -> input_ack   : (x, theta) pair handshake
//   output_activation/_stb -> output_activation_ack : result handshake
//   input_bias : signed bias, present only when ACTIVATION_BIAS_EN is defined
//   modports: slave (the activation unit), master (the streamer / result buffer side)
interface activation_mac_q_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] input_x, input_theta, output_activation;
    logic input_stb, input_ack, output_activation_stb, output_activation_ack;
`ifdef ACTIVATION_BIAS_EN
    logic [WIDTH-1:0] input_bias;
    modport slave (input input_x, input_theta, input_stb, input_bias, output_activation_ack,
                   output input_ack, output_activation, output_activation_stb);
    modport master (output input_x, input_theta, input_stb, input_bias, output_activation_ack,
                    input input_ack, output_activation, output_activation_stb);
`else
    modport slave (input input_x, input_theta, input_stb, output_activation_ack,
                   output input_ack, output_activation, output_activation_stb);
    modport master (output input_x, input_theta, input_stb, output_activation_ack,
                    input input_ack, output_activation, output_activation_stb);
`endif
endinterface

// File: rtl/activation_div_seq.sv
// activation_div_seq: unsigned restoring divider, quot = floor(num * 2^QUOT_BITS / den).
//   Requires num < den so the quotient fits in QUOT_BITS bits.
//   clk, rst (async, active-high); start loads num/den; done pulses QUOT_BITS cycles later
//   with quot valid (quot holds until the next start).
module activation_div_seq #(
    parameter int NUM_W     = 16,
    parameter int QUOT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_W-1:0]     num,
    input  logic [NUM_W-1:0]     den,
    output logic [QUOT_BITS-1:0] quot,
    output logic                 done
);
    localparam int CNT_W = $clog2(QUOT_BITS + 1);
    logic [NUM_W-1:0] rem_q, rem_d, den_q, den_d;
    logic [NUM_W:0] shifted;
    logic [QUOT_BITS-1:0] quot_q, quot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, ge;
    always_comb begin
        // the numerator's low bits are all zero, so each step shifts in a 0
        shifted = {rem_q, 1'b0};
        ge      = shifted >= {1'b0, den_q};
        rem_d   = rem_q;
        den_d   = den_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start) begin
            rem_d  = num;
            den_d  = den;
            quot_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = NUM_W'(ge ? shifted - {1'b0, den_q} : shifted);
            quot_d = QUOT_BITS'({quot_q, ge});
            cnt_d  = cnt_q + 1'b1;
            busy_d = cnt_q != CNT_W'(QUOT_BITS - 1);
            done_d = cnt_q == CNT_W'(QUOT_BITS - 1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign quot = quot_q;
    assign done = done_q;
endmodule

// File: rtl/activation_mac_q.sv
// activation_mac_q: fixed-point MAC over N_INPUTS (x, theta) pairs followed by the
// softsign sigmoid y = (1 + s/(1+|s|))/2, unsigned Q result in [0, ONE).
//   clk, rst (async, active-high)
//   bus (activation_mac_q_if.slave): input pair stream, result stream, optional input_bias
//   Optional feature: ACTIVATION_BIAS_EN adds input_bias, sampled on the first pair.
module activation_mac_q
    import activation_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int N_INPUTS = 3,
    parameter int GUARD    = 4
) (
    input logic               clk,
    input logic               rst,
    activation_mac_q_if.slave bus
);
    localparam int ACC_W = acc_width(WIDTH, GUARD);
    localparam int ONE   = one_of(FRAC);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, term, base;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] s;
    logic [WIDTH-1:0] a, y, act_q, act_d;
    logic [FRAC-1:0] quot;
    logic in_ack_q, in_ack_d, neg_q, neg_d, stb_q, stb_d, xfer, div_start, div_done;
    assign prod = $signed(bus.input_x) * $signed(bus.input_theta);
    assign term = ACC_W'(prod >>> FRAC);
`ifdef ACTIVATION_BIAS_EN
    assign base = (count_q == '0) ? ACC_W'($signed(bus.input_bias)) : acc_q;
`else
    assign base = acc_q;
`endif
    assign s = WIDTH'(saturate(64'(acc_q), WIDTH));
    // |min| does not fit, so it maps to the largest positive value
    assign a = (s == S_MIN) ? S_MAX : (s[WIDTH-1] ? WIDTH'(-s) : s);
    assign y = neg_q ? (WIDTH'(ONE) - WIDTH'(quot)) >> 1 : (WIDTH'(ONE) + WIDTH'(quot)) >> 1;
    assign xfer = in_ack_q & bus.input_stb;
    assign div_start = state_q == SAT;
    activation_div_seq #(.NUM_W(WIDTH), .QUOT_BITS(FRAC)) u_div (
        .clk(clk), .rst(rst), .start(div_start), .num(a), .den(a + WIDTH'(ONE)),
        .quot(quot), .done(div_done)
    );
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        stb_d   = stb_q;
        act_d   = act_q;
        case (state_q)
            ACCUM: if (xfer) begin
                acc_d   = base + term;
                count_d = count_q + 1'b1;
                state_d = count_q == CNT_W'(N_INPUTS - 1) ? SAT : ACCUM;
            end
            SAT: begin
                neg_d   = s[WIDTH-1];
                state_d = DIVIDE;
            end
            DIVIDE: if (div_done) begin
                act_d   = y;
                stb_d   = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: if (bus.output_activation_ack) begin
                stb_d   = 1'b0;
                acc_d   = '0;
                count_d = '0;
                state_d = ACCUM;
            end
        endcase
        in_ack_d = state_d == ACCUM;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCUM;
            count_q  <= '0;
            acc_q    <= '0;
            in_ack_q <= 1'b0;
            neg_q    <= 1'b0;
            stb_q    <= 1'b0;
            act_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            in_ack_q <= in_ack_d;
            neg_q    <= neg_d;
            stb_q    <= stb_d;
            act_q    <= act_d;
        end
    end
    assign bus.input_ack             = in_ack_q;
    assign bus.output_activation     = act_q;
    assign bus.output_activation_stb = stb_q;
endmodule

// File: tb/tb_activation_mac_q.sv
// tb_activation_mac_q: scoreboard bench for activation_mac_q (WIDTH=16, FRAC=8, N_INPUTS=3);
// exercises the bias path when ACTIVATION_BIAS_EN is defined.
module tb_activation_mac_q;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, checks = 0, errors = 0, last_acc = 0, ack_delay = 0;
    bit mon_busy = 1'b0;
    logic [15:0] exp_q[$];
`ifdef ACTIVATION_BIAS_EN
    int bias_v = 0;
`endif
    activation_mac_q_if #(.WIDTH(16)) bus();
    activation_mac_q #(.WIDTH(16), .FRAC(8), .N_INPUTS(3), .GUARD(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic send(input int x0, x1, x2, t0, t1, t2, expv, input bit push);
        int xs[3];
        int ts[3];
        xs = '{x0, x1, x2};
        ts = '{t0, t1, t2};
        if (push) exp_q.push_back(16'(expv));
        for (int i = 0; i < 3; i++) begin
            int n;
            bus.input_x = 16'(xs[i]);
            bus.input_theta = 16'(ts[i]);
            bus.input_stb = 1'b1;
`ifdef ACTIVATION_BIAS_EN
            bus.input_bias = (i == 0) ? 16'(bias_v) : 16'h1234;
`endif
            n = 0;
            while (!bus.input_ack && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!bus.input_ack) check("accept_timeout", bus.input_ack, 1);
            last_acc = cyc + 1;
            @(negedge clk);
        end
        bus.input_stb = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && bus.output_activation_stb) begin
            logic [15:0] v;
            int d;
            mon_busy = 1'b1;
            d = ack_delay;
            check("latency", cyc - last_acc, 10);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d required none", bus.output_activation);
                v = bus.output_activation;
            end else begin
                v = exp_q.pop_front();
                check("activation", bus.output_activation, v);
            end
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                check("hold_activation", bus.output_activation, v);
                check("hold_stb", bus.output_activation_stb, 1);
                check("hold_input_ack", bus.input_ack, 0);
            end
            bus.output_activation_ack = 1'b1;
            @(negedge clk);
            bus.output_activation_ack = 1'b0;
            check("stb_clear", bus.output_activation_stb, 0);
            check("input_ack_reopen", bus.input_ack, 1);
            mon_busy = 1'b0;
        end
    end

    initial begin
        int n;
        bus.input_x = '0;
        bus.input_theta = '0;
        bus.input_stb = 1'b0;
        bus.output_activation_ack = 1'b0;
`ifdef ACTIVATION_BIAS_EN
        bus.input_bias = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_activation", bus.output_activation, 0);
        check("reset_stb", bus.output_activation_stb, 0);
        check("reset_input_ack", bus.input_ack, 0);
        rst = 1'b0;
        @(negedge clk);
        check("input_ack_after_reset", bus.input_ack, 1);
        send(171, 64, 77, 128, 110, 182, 178, 1'b1);
        send(0, 0, 0, 128, 110, 182, 128, 1'b1);
        send(256, 256, 256, -256, -256, -256, 32, 1'b1);
        send(32767, 32767, 32767, 32767, 32767, 32767, 255, 1'b1);
        ack_delay = 10;
        send(171, 64, 77, 128, 110, 182, 178, 1'b1);
        n = 0;
        while (!bus.output_activation_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("backpressure_stb_seen", bus.output_activation_stb, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.input_x = 16'h7fff;
            bus.input_theta = 16'h7fff;
            bus.input_stb = (i % 2 == 0);
        end
        bus.input_stb = 1'b0;
        ack_delay = 0;
        send(171, 64, 77, 128, 110, 182, 178, 1'b1);
        send(171, 64, 77, 128, 110, 182, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_activation", bus.output_activation, 0);
        check("midreset_stb", bus.output_activation_stb, 0);
        check("midreset_input_ack", bus.input_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("input_ack_after_midreset", bus.input_ack, 1);
        send(171, 64, 77, 128, 110, 182, 178, 1'b1);
`ifdef ACTIVATION_BIAS_EN
        bias_v = -166;
        send(171, 64, 77, 128, 110, 182, 128, 1'b1);
        bias_v = 0;
`endif
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/activation_mac_q.md
# activation_mac_q

- Parametrised fixed-point neuron activation unit.
- Accepts N_INPUTS (x, theta) pairs over a valid/ack stream and accumulates their products.
- Saturates the sum and applies the softsign-based sigmoid (1 + s/(1+|s|))/2, using a sequential divider.
- Presents the result on a strobe/ack output.
- Successor to the fixed three-input float activation block.
- Sits between the weight/feature streamers and the layer result buffer.

## Interface
Parameters:
- WIDTH, 16: data width; signed two's-complement Q format.
- FRAC, 8: fractional bits; ONE = 2^FRAC; requires 1 <= FRAC <= WIDTH-2.
- N_INPUTS, 3: pairs per activation; must be >= 1.
- GUARD, 4: extra accumulator bits; ACC_W = 2*WIDTH + GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_x  in  WIDTH  signed feature.
- input_theta  in  WIDTH  signed weight.
- input_stb  in  1  pair valid.
- input_ack  out  1  block ready; a pair transfers on clk edge with input_stb & input_ack.
- output_activation  out  WIDTH  unsigned Q result in [0, ONE).
- output_activation_stb  out  1  result valid.
- output_activation_ack  in  1  result consumed when high with stb.
- input_bias  in  WIDTH  signed bias (only with ACTIVATION_BIAS_EN).

## Operation
- States: ACCUM, SAT, DIVIDE, OUTPUT.
- Reset: state ACCUM, count 0, accumulator 0, input_ack 0, output_activation 0, output_activation_stb 0.
- ACCUM:
  - input_ack is registered; it is 1 from the first edge after reset release.
  - On each transfer: acc += (x*theta) >>> FRAC (arithmetic shift, truncation toward -inf); count++.
  - On the N_INPUTS-th transfer: input_ack drops (registered), go to SAT.
- SAT: s = acc clamped to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1]; a = |s| (|min| taken as max positive); load the divider.
- DIVIDE: restoring divider computes q = floor(a*ONE / (ONE + a)), giving FRAC quotient bits in FRAC cycles.
- On completion:
  - y = (ONE + q) >> 1 if s >= 0, else (ONE - q) >> 1.
  - Register y on output_activation, set stb, go to OUTPUT.
- OUTPUT:
  - Hold output_activation and stb stable until output_activation_ack.
  - On the ack edge: stb 0, acc 0, count 0, input_ack 1, go to ACCUM.
- input_stb while input_ack=0 is ignored (no transfer, no data capture).
- Reset asserted in any state returns immediately to the reset values; any partial vector or pending result is discarded.

## Timing
- Throughput: one pair per cycle in ACCUM.
- Latency: last pair accepted at edge k ⇒ output_activation_stb high after edge k+FRAC+2.
- Ack accepted in the first cycle stb is high ⇒ input_ack high again from the following edge; next vector can start one cycle later.
- Minimum vector period: N_INPUTS + FRAC + 3 cycles.
- output_activation_ack while stb=0 has no effect.

## Configuration
- ACTIVATION_BIAS_EN defined:
  - input_bias port exists.
  - On the first transfer of each vector, acc = sign-extended input_bias + first product.
  - Bias is sampled only at that transfer.
- ACTIVATION_BIAS_EN undefined:
  - No input_bias port.
  - acc starts at 0 each vector.

## Structure
- Package activation_pkg holds:
  - the state enum (ACCUM, SAT, DIVIDE, OUTPUT);
  - the saturate function;
  - the ONE/ACC_W localparam helpers.
- One sub-module: activation_div_seq.
  - Unsigned restoring divider with start/done.
  - Parameters NUM_W, QUOT_BITS.
  - Fixed latency of QUOT_BITS cycles from start to done.
- The top holds the MAC, the FSM and the handshake logic.

## Test plan
All cases use WIDTH=16, FRAC=8, N_INPUTS=3, bias off unless stated.
- Nominal vector:
  - x = {171, 64, 77}, theta = {128, 110, 182}, streamed back-to-back.
  - Products 85, 27, 54 give s=166 and q=100.
  - Required: output_activation = 178 (0x00B2), stb exactly FRAC+2 = 10 cycles after the last accept.
- Zero and negative:
  - All x = 0 ⇒ 128.
  - x = {256, 256, 256}, theta = {-256, -256, -256} ⇒ s=-768, q=192, output = 32.
- Saturation: x = theta = 32767 for all pairs ⇒ sum clamps to 32767, q=254, output = 255.
- Backpressure:
  - Hold output_activation_ack low for 10 cycles.
  - Required: output and stb stable, input_ack 0, and input_stb pulses are not absorbed.
  - Then ack ⇒ input_ack 1 on the next cycle.
- Reset mid-DIVIDE:
  - Assert rst during cycle 4 of DIVIDE.
  - Required: all outputs 0 immediately; the next vector (the nominal one) yields 178.
- Bias (ACTIVATION_BIAS_EN): input_bias = -166 with the nominal vector ⇒ s=0, output = 128.
